// File: rtl/wb_unit_pkg.sv
// Shared encodings for the writeback stage: writeback mux select, load funct3, FSM states.
// Ports: none (package only).
// Imported by wb_unit and its load extraction sub-module.
package wb_unit_pkg;

  // Writeback data source (control_wr_mux_i); 2'b11 is reserved and behaves as ALU.
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC  = 2'b10;

  // Load type, RISC-V funct3 encoding.
  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_unit_load_extract.sv
// Load data alignment: picks byte/halfword/word out of a word-aligned read and extends it.
// Ports: rdata (word from memory), offset (byte offset), load_type (funct3) -> data (32-bit result).
// Purely combinational, zero latency, no backpressure.
module wb_unit_load_extract
  import wb_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
  end

  // Halfword loads only look at offset[1]; a misaligned offset[0] is ignored.
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (load_type)
      LOAD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: data = {24'h000000, byte_sel};
      LOAD_LH:  data = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: data = {16'h0000, half_sel};
      LOAD_LW:  data = rdata;
      default:  data = rdata;  // undefined funct3 returns the raw word
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: selects ALU/MEM/PC+4 result, drives the regfile write port, waits on loads.
// Ports: EX/WB bundle + dmem read response in; regfile write port, stall, instret, sticky err out.
// Completion and stall are combinational in the cycle; a missing load response stalls upstream
// until data arrives or TIMEOUT cycles elapse, after which the load is dropped and err sets.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid_i,
  input  logic             control_wb_i,
  input  logic [4:0]       wb_addr_i,
  input  logic [31:0]      alu_result_i,
  input  logic [31:0]      pc_plus_i,
  input  logic [1:0]       control_wr_mux_i,
  input  logic [2:0]       control_load_i,
  input  logic [1:0]       addr_offset_i,
  input  logic             dmem_rvalid_i,
  input  logic [31:0]      dmem_rdata_i,
  output logic             rf_we_o,
  output logic [4:0]       rf_waddr_o,
  output logic [31:0]      rf_wdata_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             err_o
);

  localparam int            TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  wb_state_t     state;
  logic [TW-1:0] tcnt;
  logic          is_load;
  logic          complete;
  logic          timeout;
  logic          stall;
  logic [31:0]   load_data;

  assign is_load = wb_valid_i & (control_wr_mux_i == WB_SEL_MEM);

  wb_unit_load_extract u_extract (
    .rdata     (dmem_rdata_i),
    .offset    (addr_offset_i),
    .load_type (control_load_i),
    .data      (load_data)
  );

  // complete: the instruction in EX/WB retires this cycle.
  // timeout:  the outstanding load is abandoned this cycle.
  always_comb begin
    stall    = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (wb_valid_i) begin
          if (is_load && !dmem_rvalid_i) stall = 1'b1;
          else                           complete = 1'b1;
        end
      end
      WAIT_MEM: begin
        // A response arriving on the final cycle still wins over the timeout.
        if (dmem_rvalid_i)     complete = 1'b1;
        else if (tcnt >= TMAX) timeout = 1'b1;
        else                   stall = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall_o    = stall;
  assign rf_we_o    = complete & control_wb_i & (wb_addr_i != 5'd0);
  assign rf_waddr_o = wb_addr_i;

  always_comb begin
    rf_wdata_o = alu_result_i;
    case (control_wr_mux_i)
      WB_SEL_ALU: rf_wdata_o = alu_result_i;
      WB_SEL_MEM: rf_wdata_o = load_data;
      WB_SEL_PC:  rf_wdata_o = pc_plus_i;
      default:    rf_wdata_o = alu_result_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      instret_o <= '0;
      err_o     <= 1'b0;
    end else begin
      if (complete) instret_o <= instret_o + CNT_W'(1);
      if (timeout)  err_o     <= 1'b1;
      case (state)
        IDLE: begin
          if (stall) begin
            state <= WAIT_MEM;
            tcnt  <= TW'(1);
          end
        end
        WAIT_MEM: begin
          if (complete || timeout) begin
            state <= IDLE;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: single-cycle vector table plus multi-cycle load sequences.
// Ports: none (top-level bench).
// Runs wb_unit with TIMEOUT=4 so the timeout path is short.
module tb_wb_unit;

  logic        clk;
  logic        rst_n;
  logic        wb_valid_i;
  logic        control_wb_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] alu_result_i;
  logic [31:0] pc_plus_i;
  logic [1:0]  control_wr_mux_i;
  logic [2:0]  control_load_i;
  logic [1:0]  addr_offset_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        stall_o;
  logic [63:0] instret_o;
  logic        err_o;

  wb_unit #(.TIMEOUT(4), .CNT_W(64)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wb_valid_i       (wb_valid_i),
    .control_wb_i     (control_wb_i),
    .wb_addr_i        (wb_addr_i),
    .alu_result_i     (alu_result_i),
    .pc_plus_i        (pc_plus_i),
    .control_wr_mux_i (control_wr_mux_i),
    .control_load_i   (control_load_i),
    .addr_offset_i    (addr_offset_i),
    .dmem_rvalid_i    (dmem_rvalid_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .rf_we_o          (rf_we_o),
    .rf_waddr_o       (rf_waddr_o),
    .rf_wdata_o       (rf_wdata_o),
    .stall_o          (stall_o),
    .instret_o        (instret_o),
    .err_o            (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        wbe;
    logic [4:0]  addr;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [1:0]  mux;
    logic [2:0]  ld;
    logic [1:0]  off;
    logic        rv;
    logic [31:0] rdata;
    logic        e_we;
    logic [31:0] e_wdata;
    logic        e_ret;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  int          checks;
  int          errors;
  logic [63:0] exp_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    wb_valid_i       = v.valid;
    control_wb_i     = v.wbe;
    wb_addr_i        = v.addr;
    alu_result_i     = v.alu;
    pc_plus_i        = v.pc;
    control_wr_mux_i = v.mux;
    control_load_i   = v.ld;
    addr_offset_i    = v.off;
    dmem_rvalid_i    = v.rv;
    dmem_rdata_i     = v.rdata;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 64'd0;

    //          vld wbe addr  alu           pc            mux    ld      off   rv    rdata         we    wdata         ret
    vecs[0]  = '{1'b1, 1'b1, 5'd5,  32'h00001234, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0, 32'h0,        1'b1, 32'h00001234, 1'b1}; // ALU
    vecs[1]  = '{1'b1, 1'b1, 5'd6,  32'h0,        32'h0,        2'b01, 3'b000, 2'd3, 1'b1, 32'h80FF0000, 1'b1, 32'hFFFFFF80, 1'b1}; // LB off3
    vecs[2]  = '{1'b1, 1'b1, 5'd6,  32'h0,        32'h0,        2'b01, 3'b100, 2'd2, 1'b1, 32'h80FF0000, 1'b1, 32'h000000FF, 1'b1}; // LBU off2
    vecs[3]  = '{1'b1, 1'b1, 5'd7,  32'h0,        32'h0,        2'b01, 3'b001, 2'd0, 1'b1, 32'h80017FFF, 1'b1, 32'h00007FFF, 1'b1}; // LH low
    vecs[4]  = '{1'b1, 1'b1, 5'd7,  32'h0,        32'h0,        2'b01, 3'b101, 2'd3, 1'b1, 32'h80017FFF, 1'b1, 32'h00008001, 1'b1}; // LHU off3
    vecs[5]  = '{1'b1, 1'b1, 5'd8,  32'h0,        32'h0,        2'b01, 3'b010, 2'd1, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1}; // LW
    vecs[6]  = '{1'b1, 1'b1, 5'd0,  32'h0,        32'h00000104, 2'b10, 3'b000, 2'd0, 1'b0, 32'h0,        1'b0, 32'h00000104, 1'b1}; // JAL x0
    vecs[7]  = '{1'b1, 1'b1, 5'd1,  32'h0,        32'h00000100, 2'b10, 3'b000, 2'd0, 1'b0, 32'h0,        1'b1, 32'h00000100, 1'b1}; // JAL ra
    vecs[8]  = '{1'b0, 1'b1, 5'd9,  32'h00000055, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0, 32'h0,        1'b0, 32'h00000055, 1'b0}; // bubble
    vecs[9]  = '{1'b1, 1'b1, 5'd10, 32'h0000CAFE, 32'h0,        2'b11, 3'b000, 2'd0, 1'b0, 32'h0,        1'b1, 32'h0000CAFE, 1'b1}; // mux 11
    vecs[10] = '{1'b1, 1'b0, 5'd11, 32'h00000077, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0, 32'h0,        1'b0, 32'h00000077, 1'b1}; // no rd
    vecs[11] = '{1'b0, 1'b1, 5'd12, 32'h0,        32'h0,        2'b01, 3'b000, 2'd0, 1'b1, 32'h12345678, 1'b0, 32'h00000078, 1'b0}; // stray rvalid
    vecs[12] = '{1'b1, 1'b1, 5'd13, 32'h0,        32'h0,        2'b01, 3'b000, 2'd1, 1'b1, 32'h00007F00, 1'b1, 32'h0000007F, 1'b1}; // LB positive
    vecs[13] = '{1'b1, 1'b1, 5'd14, 32'h0,        32'h0,        2'b01, 3'b011, 2'd2, 1'b1, 32'hA5A5C3C3, 1'b1, 32'hA5A5C3C3, 1'b1}; // funct3 011
    vecs[14] = '{1'b1, 1'b1, 5'd15, 32'h0,        32'h0,        2'b01, 3'b001, 2'd2, 1'b1, 32'h80017FFF, 1'b1, 32'hFFFF8001, 1'b1}; // LH high

    // Reset state
    rst_n = 1'b0;
    apply('{1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 3'b000, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0});
    #12;
    chk("reset_stall", {63'd0, stall_o}, 64'd0);
    chk("reset_we", {63'd0, rf_we_o}, 64'd0);
    chk("reset_instret", instret_o, 64'd0);
    chk("reset_err", {63'd0, err_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk($sformatf("vec%0d_stall", i), {63'd0, stall_o}, 64'd0);
      chk($sformatf("vec%0d_we", i), {63'd0, rf_we_o}, {63'd0, vecs[i].e_we});
      chk($sformatf("vec%0d_waddr", i), {59'd0, rf_waddr_o}, {59'd0, vecs[i].addr});
      if (vecs[i].e_we)
        chk($sformatf("vec%0d_wdata", i), {32'd0, rf_wdata_o}, {32'd0, vecs[i].e_wdata});
      if (vecs[i].e_ret) exp_cnt = exp_cnt + 64'd1;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_instret", i), instret_o, exp_cnt);
    end

    // LH at offset 2 with response 3 cycles late
    @(negedge clk);
    apply('{1'b1, 1'b1, 5'd20, 32'h0, 32'h0, 2'b01, 3'b001, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0});
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("lh_wait%0d_stall", c), {63'd0, stall_o}, 64'd1);
      chk($sformatf("lh_wait%0d_we", c), {63'd0, rf_we_o}, 64'd0);
      @(negedge clk);
      chk($sformatf("lh_wait%0d_instret", c), instret_o, exp_cnt);
    end
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h80017FFF;
    #1;
    chk("lh_done_stall", {63'd0, stall_o}, 64'd0);
    chk("lh_done_we", {63'd0, rf_we_o}, 64'd1);
    chk("lh_done_wdata", {32'd0, rf_wdata_o}, 64'h00000000FFFF8001);
    exp_cnt = exp_cnt + 64'd1;
    @(posedge clk);
    #1;
    chk("lh_done_instret", instret_o, exp_cnt);
    @(negedge clk);
    apply('{1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 3'b000, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0});
    @(posedge clk);
    #1;
    chk("lh_once_instret", instret_o, exp_cnt);

    // Load timeout with TIMEOUT=4
    @(negedge clk);
    apply('{1'b1, 1'b1, 5'd21, 32'h0, 32'h0, 2'b01, 3'b010, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0});
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("to_wait%0d_stall", c), {63'd0, stall_o}, 64'd1);
      @(negedge clk);
    end
    #1;
    chk("to_release_stall", {63'd0, stall_o}, 64'd0);
    chk("to_release_we", {63'd0, rf_we_o}, 64'd0);
    chk("to_release_err_pre", {63'd0, err_o}, 64'd0);
    @(posedge clk);
    #1;
    chk("to_err", {63'd0, err_o}, 64'd1);
    chk("to_instret", instret_o, exp_cnt);
    @(negedge clk);
    apply('{1'b1, 1'b1, 5'd22, 32'h00000042, 32'h0, 2'b00, 3'b000, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0});
    #1;
    chk("post_to_we", {63'd0, rf_we_o}, 64'd1);
    chk("post_to_stall", {63'd0, stall_o}, 64'd0);
    exp_cnt = exp_cnt + 64'd1;
    @(posedge clk);
    #1;
    chk("post_to_err", {63'd0, err_o}, 64'd1);
    chk("post_to_instret", instret_o, exp_cnt);

    // Reset pulse in the middle of a wait
    @(negedge clk);
    apply('{1'b1, 1'b1, 5'd23, 32'h0, 32'h0, 2'b01, 3'b010, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0});
    @(negedge clk);
    #1;
    chk("rst_pre_stall", {63'd0, stall_o}, 64'd1);
    rst_n      = 1'b0;
    wb_valid_i = 1'b0;
    #1;
    chk("rst_mid_stall", {63'd0, stall_o}, 64'd0);
    chk("rst_mid_instret", instret_o, 64'd0);
    chk("rst_mid_err", {63'd0, err_o}, 64'd0);
    exp_cnt = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hFFFFFFFF;
    #1;
    chk("late_rvalid_we", {63'd0, rf_we_o}, 64'd0);
    chk("late_rvalid_stall", {63'd0, stall_o}, 64'd0);
    @(posedge clk);
    #1;
    chk("late_rvalid_instret", instret_o, exp_cnt);
    chk("late_rvalid_err", {63'd0, err_o}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
